// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline: latch enables/flushes,
// PC write enable, halt draining, stall-cycle accounting and a data-memory watchdog.
module pipeline_hazard_ctrl #(
  parameter int CNT_W        = 32,
  parameter int DMEM_TIMEOUT = 64
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             exmem_load,
  input  logic             exmem_store,
  input  logic             exmem_brtaken,
  input  logic             idex_load,
  input  logic [4:0]       idex_rt,
  input  logic [4:0]       ifid_rs,
  input  logic [4:0]       ifid_rt,
  input  logic             ifid_jump,
  input  logic             ifid_halt,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt_o,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  // state  | meaning
  // RUN    | normal issue, hazards resolved by priority
  // DRAIN  | HALT decoded, fetch stopped, older instrs retire
  // HALTED | pipeline frozen until reset
  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  localparam int WD_W = $clog2(DMEM_TIMEOUT + 1);

  state_t          state, state_nx;
  logic [WD_W-1:0] wd_cnt;
  logic            dstall, lduse;

  assign dstall = (exmem_load | exmem_store) & ~dhit;
  assign lduse  = idex_load & (idex_rt != 5'd0) &
                  ((idex_rt == ifid_rs) | (idex_rt == ifid_rt));

  always_comb begin
    state_nx    = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    memwb_flush = 1'b0;
    if (RST) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
      {ifid_flush, idex_flush, exmem_flush, memwb_flush} = '1;
    end else begin
      case (state)
        RUN: begin
          if (dstall) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else if (exmem_brtaken) begin
            {ifid_en, idex_en, exmem_en} = '0;
            {ifid_flush, idex_flush, exmem_flush} = '1;
          end else if (lduse) begin
            {pc_en, ifid_en, idex_en} = '0;
            idex_flush = 1'b1;
          end else if (!ihit || ifid_halt) begin
            {pc_en, ifid_en} = '0;
            ifid_flush = 1'b1;
          end else if (ifid_jump) begin
            ifid_en    = 1'b0;
            ifid_flush = 1'b1;
          end
          if (ifid_halt && !dstall && !exmem_brtaken) state_nx = DRAIN;
        end
        DRAIN: begin
          if (dstall) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
          end else if (exmem_brtaken) begin
            // branch older than the HALT squashes it; resume fetching
            {ifid_en, idex_en, exmem_en} = '0;
            {ifid_flush, idex_flush, exmem_flush} = '1;
            state_nx = RUN;
          end else begin
            {pc_en, ifid_en} = '0;
            ifid_flush = 1'b1;
            if (memwb_halt) state_nx = HALTED;
          end
        end
        HALTED: begin
          {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = '0;
        end
        default: state_nx = RUN;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= RUN;
      halt_o       <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state  <= state_nx;
      halt_o <= (state == HALTED);
      if (state != HALTED && !pc_en && !(&stall_cycles))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  // watchdog saturates at the timeout so it cannot wrap back below it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wd_cnt  <= '0;
      mem_err <= 1'b0;
    end else if (dstall) begin
      if (wd_cnt != WD_W'(DMEM_TIMEOUT)) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt == WD_W'(DMEM_TIMEOUT - 1)) mem_err <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios then random traffic, all checked
// against a table-driven reference model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 8;
  localparam int TO    = 4;

  logic CLK = 1'b0;
  logic RST;
  logic ihit, dhit, exmem_load, exmem_store, exmem_brtaken, idex_load;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic ifid_jump, ifid_halt, memwb_halt;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, exmem_flush, memwb_flush;
  logic halt_o, mem_err;
  logic [CNT_W-1:0] stall_cycles;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state: 0 run, 1 drain, 2 halted
  int m_state, m_stall, m_wd;
  logic m_halt, m_err;

  always #5 CLK = ~CLK;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TO)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .exmem_load(exmem_load),
    .exmem_store(exmem_store), .exmem_brtaken(exmem_brtaken), .idex_load(idex_load),
    .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_jump(ifid_jump),
    .ifid_halt(ifid_halt), .memwb_halt(memwb_halt), .pc_en(pc_en), .ifid_en(ifid_en),
    .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .exmem_flush(exmem_flush), .memwb_flush(memwb_flush),
    .halt_o(halt_o), .mem_err(mem_err), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic ds_f();
    return (exmem_load | exmem_store) & ~dhit;
  endfunction

  function automatic logic lu_f();
    return idex_load && idex_rt != 0 && (idex_rt == ifid_rs || idex_rt == ifid_rt);
  endfunction

  // {pc_en, en ifid/idex/exmem/memwb, flush ifid/idex/exmem/memwb}
  function automatic logic [8:0] model_ctl();
    if (RST) return 9'b0_0000_1111;
    if (m_state == 2 || ds_f()) return 9'b0_0000_0000;
    if (exmem_brtaken) return 9'b1_0001_1110;
    if (m_state == 1) return 9'b0_0111_1000;
    if (lu_f()) return 9'b0_0011_0100;
    if (!ihit || ifid_halt) return 9'b0_0111_1000;
    if (ifid_jump) return 9'b1_0111_1000;
    return 9'b1_1111_0000;
  endfunction

  task automatic model_reset();
    m_state = 0; m_stall = 0; m_wd = 0; m_halt = 1'b0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic [8:0] ctl);
    logic ds;
    if (RST) begin
      model_reset();
      return;
    end
    ds = ds_f();
    if (m_state != 2 && !ctl[8] && m_stall < 255) m_stall++;
    if (ds) begin
      m_wd++;
      if (m_wd >= TO) m_err = 1'b1;
    end else m_wd = 0;
    m_halt = (m_state == 2);
    if (m_state == 0 && ifid_halt && !ds && !exmem_brtaken) m_state = 1;
    else if (m_state == 1 && !ds && exmem_brtaken) m_state = 0;
    else if (m_state == 1 && !ds && memwb_halt) m_state = 2;
  endtask

  // inputs are set at the falling edge; check, then advance one clock
  task automatic cyc();
    logic [8:0] exp;
    #1;
    if (RST) model_reset();
    exp = model_ctl();
    chk("ctl", {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush, memwb_flush}, 32'(exp));
    chk("halt_o", halt_o, m_halt);
    chk("mem_err", mem_err, m_err);
    chk("stall_cycles", stall_cycles, m_stall);
    @(posedge CLK);
    model_step(exp);
    @(negedge CLK);
  endtask

  task automatic idle();
    ihit = 1; dhit = 1; exmem_load = 0; exmem_store = 0; exmem_brtaken = 0;
    idex_load = 0; idex_rt = 0; ifid_rs = 0; ifid_rt = 0;
    ifid_jump = 0; ifid_halt = 0; memwb_halt = 0;
  endtask

  task automatic pulse_rst();
    idle(); RST = 1; cyc(); RST = 0;
  endtask

  initial begin
    idle();
    RST = 1;
    model_reset();
    @(negedge CLK);
    cyc();
    chk("rst_flush", {ifid_flush, idex_flush, exmem_flush, memwb_flush}, 4'hf);
    RST = 0;
    idle(); cyc();

    // load-use on rs
    idex_load = 1; idex_rt = 5; ifid_rs = 5; cyc();
    chk("lduse_stall", stall_cycles, 1);
    // r0 never stalls; rt match on r9 does
    idle(); idex_load = 1; idex_rt = 0; ifid_rs = 0; cyc();
    idle(); idex_load = 1; idex_rt = 9; ifid_rt = 9; cyc();

    // branch blocked by dmem stall, then resolves
    idle(); exmem_brtaken = 1; exmem_load = 1; dhit = 0; cyc();
    dhit = 1; #1;
    chk("br_pc_en", pc_en, 1);
    chk("br_memwb_en", memwb_en, 1);
    cyc();
    idle(); exmem_brtaken = 1; ihit = 0; cyc();
    idle(); ifid_jump = 1; cyc();

    // halt drain into HALTED
    idle(); ifid_halt = 1; cyc();
    idle(); cyc(); cyc();
    memwb_halt = 1; cyc();
    idle();
    for (int i = 0; i < 10; i++) cyc();
    chk("halted_halt_o", halt_o, 1);
    pulse_rst();

    // speculative halt squashed by older branch
    idle(); ifid_halt = 1; cyc();
    idle(); exmem_brtaken = 1; cyc();
    idle(); cyc(); cyc();
    chk("squash_halt_o", halt_o, 0);

    // watchdog
    idle(); exmem_store = 1; dhit = 0;
    for (int i = 0; i < 3; i++) cyc();
    chk("wd_before", mem_err, 0);
    cyc();
    chk("wd_trip", mem_err, 1);
    dhit = 1; cyc(); cyc();
    dhit = 0; cyc();
    RST = 1; cyc(); RST = 0;
    chk("wd_cleared", mem_err, 0);
    idle(); cyc();

    // stall counter saturation
    ihit = 0;
    for (int i = 0; i < 260; i++) cyc();
    chk("stall_sat", stall_cycles, 255);
    pulse_rst();

    for (int i = 0; i < 3000; i++) begin
      RST           = ($urandom_range(0, 149) == 0);
      ihit          = ($urandom_range(0, 9) != 0);
      dhit          = ($urandom_range(0, 4) != 0);
      exmem_load    = ($urandom_range(0, 3) == 0);
      exmem_store   = ($urandom_range(0, 3) == 0);
      exmem_brtaken = ($urandom_range(0, 9) == 0);
      idex_load     = $urandom_range(0, 1);
      idex_rt       = 5'($urandom_range(0, 3));
      ifid_rs       = 5'($urandom_range(0, 3));
      ifid_rt       = 5'($urandom_range(0, 3));
      ifid_jump     = ($urandom_range(0, 9) == 0);
      ifid_halt     = ($urandom_range(0, 11) == 0);
      memwb_halt    = ($urandom_range(0, 4) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
